// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   RESET_PC_DEFAULT  : first fetch address after reset
//   NOP_INSTR_DEFAULT : IF/ID contents when empty or flushed (sll $0,$0,0)
//   fetch_state_e     : fetch controller states
//   pc_plus4          : sequential PC increment, wraps modulo 2^32
//   word_align        : clears the byte-offset bits of an address
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        DRAIN = 2'b01,
        HOLD  = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req_o   : fetch request (held until acknowledged)
//   imem_addr_o  : word-aligned fetch address
//   imem_ack_i   : imem_rdata_i valid for the current request
//   imem_rdata_i : instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, reset         : clock, synchronous active-high reset
//   flush              : invalidate contents (highest priority after reset)
//   stall              : hold current contents
//   load               : capture load_instr/load_pc4 as a valid instruction
//   instr, pc4, valid  : registered IF/ID contents
// With no stall and nothing to load, the register takes a bubble so that
// decode never sees the same instruction twice.
module if_id_register
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // IF/ID update: reset > flush > stall > load > bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else if (stall) begin
            instr <= instr;
            pc4   <= pc4;
            valid <= valid;
        end else if (load) begin
            instr <= load_instr;
            pc4   <= load_pc4;
            valid <= 1'b1;
        end else begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage.
//   clk, reset      : clock, synchronous active-high reset
//   stall_i         : decode cannot accept; IF/ID holds
//   flush_i         : invalidate IF/ID this cycle
//   redirect_i      : next fetch goes to redirect_pc_i (bits [1:0] ignored)
//   imem            : instruction-memory bus (master side)
//   if_id_instr_o   : IF/ID instruction, opcode in [31:26]
//   if_id_pc4_o     : PC+4 of that instruction
//   if_id_valid_o   : IF/ID holds a real instruction
// One request is outstanding at a time. A redirect that arrives while a
// request is outstanding parks the target in pc_r and the controller
// waits in DRAIN for the stale response before fetching the target.
// A response that arrives while decode is stalled on a valid instruction
// is parked in a one-entry skid buffer (HOLD).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    fetch_stage_if.master      imem,
    output logic [31:0]        if_id_instr_o,
    output logic [31:0]        if_id_pc4_o,
    output logic               if_id_valid_o
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] req_addr_r;
    logic [31:0] req_addr_next_s;
    logic        req_r;
    logic        req_next_s;

    logic [31:0] buf_instr_r;
    logic [31:0] buf_pc4_r;
    logic        buf_load_s;

    logic        ack_s;
    logic [31:0] target_s;
    logic [31:0] addr_pc4_s;
    logic        ifid_load_s;
    logic [31:0] ifid_load_instr_s;
    logic [31:0] ifid_load_pc4_s;
    logic        ifid_stall_s;

    // An ack only counts while a request is actually on the bus
    assign ack_s      = imem.imem_ack_i & req_r;
    assign target_s   = word_align(redirect_pc_i);
    assign addr_pc4_s = pc_plus4(req_addr_r);

    // A stall only needs to hold IF/ID when it carries a real instruction
    assign ifid_stall_s = stall_i & if_id_valid_o;

    assign imem.imem_req_o  = req_r;
    assign imem.imem_addr_o = req_addr_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, address update and IF/ID load selection
    always_comb begin
        state_next_s      = state_r;
        pc_next_s         = pc_r;
        req_addr_next_s   = req_addr_r;
        buf_load_s        = 1'b0;
        ifid_load_s       = 1'b0;
        ifid_load_instr_s = imem.imem_rdata_i;
        ifid_load_pc4_s   = addr_pc4_s;

        case (state_r)
            FETCH: begin
                if (ack_s) begin
                    if (redirect_i) begin
                        // Response belongs to the wrong path
                        req_addr_next_s = target_s;
                    end else if (flush_i) begin
                        // Flush discards the word but the stream advances
                        req_addr_next_s = addr_pc4_s;
                    end else if (stall_i && if_id_valid_o) begin
                        buf_load_s      = 1'b1;
                        req_addr_next_s = addr_pc4_s;
                        state_next_s    = HOLD;
                    end else begin
                        ifid_load_s     = 1'b1;
                        req_addr_next_s = addr_pc4_s;
                    end
                end else if (redirect_i) begin
                    if (req_r) begin
                        // Request in flight: remember target, drain old response
                        pc_next_s    = target_s;
                        state_next_s = DRAIN;
                    end else begin
                        req_addr_next_s = target_s;
                    end
                end else begin
                    state_next_s = FETCH;
                end
            end

            DRAIN: begin
                if (ack_s) begin
                    // A redirect coinciding with the ack is the newest target
                    if (redirect_i) begin
                        req_addr_next_s = target_s;
                    end else begin
                        req_addr_next_s = pc_r;
                    end
                    state_next_s = FETCH;
                end else if (redirect_i) begin
                    pc_next_s = target_s;
                end else begin
                    state_next_s = DRAIN;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    req_addr_next_s = target_s;
                    state_next_s    = FETCH;
                end else if (flush_i) begin
                    // Buffered word is dropped; req_addr_r already points past it
                    state_next_s = FETCH;
                end else if (!stall_i) begin
                    ifid_load_s       = 1'b1;
                    ifid_load_instr_s = buf_instr_r;
                    ifid_load_pc4_s   = buf_pc4_r;
                    state_next_s      = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end

            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // Request is on the bus in every state except HOLD
    assign req_next_s = (state_next_s != HOLD);

    // Fetch PC, request address and request strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            req_r      <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            req_addr_r <= req_addr_next_s;
            req_r      <= req_next_s;
        end
    end

    // Skid buffer for a response that arrives during a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_instr_r <= NOP_INSTR;
            buf_pc4_r   <= 32'h0000_0000;
        end else if (buf_load_s) begin
            buf_instr_r <= imem.imem_rdata_i;
            buf_pc4_r   <= addr_pc4_s;
        end else begin
            buf_instr_r <= buf_instr_r;
            buf_pc4_r   <= buf_pc4_r;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_i),
        .stall      (ifid_stall_s),
        .load       (ifid_load_s),
        .load_instr (ifid_load_instr_s),
        .load_pc4   (ifid_load_pc4_s),
        .instr      (if_id_instr_o),
        .pc4        (if_id_pc4_o),
        .valid      (if_id_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The memory model answers every
// request after mem_lat wait cycles with addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 0;
    int          wait_cnt = 0;
    logic        mem_ack;

    fetch_stage_if mem_bus ();

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (mem_bus),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model
    assign mem_ack              = mem_bus.imem_req_o && (wait_cnt >= mem_lat);
    assign mem_bus.imem_ack_i   = mem_ack;
    assign mem_bus.imem_rdata_i = mem_bus.imem_addr_o ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (!mem_bus.imem_req_o || mem_ack) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, check reset values, release; returns at negedge of first request cycle
    task automatic do_reset();
        reset = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0000_0000;
        tick();
        tick();
        check_eq("rst_req",   {31'd0, mem_bus.imem_req_o}, 32'h0000_0000);
        check_eq("rst_addr",  mem_bus.imem_addr_o, 32'h0040_0000);
        check_eq("rst_instr", if_id_instr_o, 32'h0000_0000);
        check_eq("rst_pc4",   if_id_pc4_o, 32'h0000_0000);
        check_eq("rst_valid", {31'd0, if_id_valid_o}, 32'h0000_0000);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0000_0000;

        // Zero-wait streaming
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check_eq("seq_req",  {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
            check_eq("seq_addr", mem_bus.imem_addr_o, 32'h0040_0000 + 32'(4 * i));
            if (i == 0) begin
                check_eq("seq_valid0", {31'd0, if_id_valid_o}, 32'h0000_0000);
            end else begin
                check_eq("seq_pc4",   if_id_pc4_o, 32'h0040_0000 + 32'(4 * i));
                check_eq("seq_instr", if_id_instr_o,
                         (32'h0040_0000 + 32'(4 * (i - 1))) ^ 32'hA5A5_0000);
                check_eq("seq_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
            end
            tick();
        end

        // 3-wait memory, redirect one cycle after the request
        mem_lat = 3;
        do_reset();
        check_eq("rd_req0", mem_bus.imem_addr_o, 32'h0040_0000);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0040_0100;
        tick();
        redirect_i = 1'b0;
        check_eq("rd_drain_addr", mem_bus.imem_addr_o, 32'h0040_0000);
        check_eq("rd_drain_req", {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        tick();
        check_eq("rd_drain_addr2", mem_bus.imem_addr_o, 32'h0040_0000);
        check_eq("rd_drain_valid", {31'd0, if_id_valid_o}, 32'h0000_0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("rd_tgt_addr", mem_bus.imem_addr_o, 32'h0040_0100);
            check_eq("rd_tgt_req", {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
            check_eq("rd_no_stale", {31'd0, if_id_valid_o}, 32'h0000_0000);
            tick();
        end
        check_eq("rd_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
        check_eq("rd_pc4",   if_id_pc4_o, 32'h0040_0104);
        check_eq("rd_instr", if_id_instr_o, 32'hA5E5_0100);

        // Stall held 4 cycles while an ack arrives
        mem_lat = 0;
        do_reset();
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("st_req",   {31'd0, mem_bus.imem_req_o}, 32'h0000_0000);
            check_eq("st_pc4",   if_id_pc4_o, 32'h0040_0004);
            check_eq("st_instr", if_id_instr_o, 32'hA5E5_0000);
            check_eq("st_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
        end
        tick();
        stall_i = 1'b0;
        check_eq("st_fall_pc4", if_id_pc4_o, 32'h0040_0004);
        check_eq("st_fall_req", {31'd0, mem_bus.imem_req_o}, 32'h0000_0000);
        tick();
        check_eq("st_buf_pc4",   if_id_pc4_o, 32'h0040_0008);
        check_eq("st_buf_instr", if_id_instr_o, 32'hA5E5_0004);
        check_eq("st_buf_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
        check_eq("st_resume_addr", mem_bus.imem_addr_o, 32'h0040_0008);
        check_eq("st_resume_req", {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        tick();
        check_eq("st_next_pc4",   if_id_pc4_o, 32'h0040_000C);
        check_eq("st_next_instr", if_id_instr_o, 32'hA5E5_0008);

        // Flush together with stall and an ack
        do_reset();
        tick();
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        stall_i = 1'b0;
        flush_i = 1'b0;
        check_eq("fl_valid", {31'd0, if_id_valid_o}, 32'h0000_0000);
        check_eq("fl_instr", if_id_instr_o, 32'h0000_0000);
        check_eq("fl_pc4",   if_id_pc4_o, 32'h0000_0000);
        check_eq("fl_addr",  mem_bus.imem_addr_o, 32'h0040_0008);
        check_eq("fl_req",   {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        tick();
        check_eq("fl_next_pc4",   if_id_pc4_o, 32'h0040_000C);
        check_eq("fl_next_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
        check_eq("fl_next_instr", if_id_instr_o, 32'hA5E5_0008);

        // Redirect to top of address space, PC+4 wrap
        do_reset();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        check_eq("wr_addr", mem_bus.imem_addr_o, 32'hFFFF_FFFC);
        check_eq("wr_req",  {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        tick();
        check_eq("wr_next_addr", mem_bus.imem_addr_o, 32'h0000_0000);
        check_eq("wr_pc4",       if_id_pc4_o, 32'h0000_0000);
        check_eq("wr_valid",     {31'd0, if_id_valid_o}, 32'h0000_0001);
        check_eq("wr_instr",     if_id_instr_o, 32'h5A5A_FFFC);

        // Reset during DRAIN
        mem_lat = 3;
        do_reset();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0040_0200;
        tick();
        redirect_i = 1'b0;
        check_eq("rdr_req",  {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        check_eq("rdr_addr", mem_bus.imem_addr_o, 32'h0040_0000);
        reset = 1'b1;
        tick();
        check_eq("rdr_rst_req",   {31'd0, mem_bus.imem_req_o}, 32'h0000_0000);
        check_eq("rdr_rst_addr",  mem_bus.imem_addr_o, 32'h0040_0000);
        check_eq("rdr_rst_instr", if_id_instr_o, 32'h0000_0000);
        check_eq("rdr_rst_pc4",   if_id_pc4_o, 32'h0000_0000);
        check_eq("rdr_rst_valid", {31'd0, if_id_valid_o}, 32'h0000_0000);
        reset = 1'b0;
        tick();
        check_eq("rdr_restart_req",  {31'd0, mem_bus.imem_req_o}, 32'h0000_0001);
        check_eq("rdr_restart_addr", mem_bus.imem_addr_o, 32'h0040_0000);
        repeat (4) tick();
        check_eq("rdr_restart_valid", {31'd0, if_id_valid_o}, 32'h0000_0001);
        check_eq("rdr_restart_pc4",   if_id_pc4_o, 32'h0040_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register whose `instr[31:26]` drives the decode-stage control unit's opcode input. It supports decode stalls, IF/ID flushes, and PC redirects from branch/jump resolution. Redirects may arrive while a memory request is still outstanding.

## Interface
- `RESET_PC`, default 32'h0040_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0000 (`sll $0,$0,0`): IF/ID contents when empty or flushed.
- `clk`  in  1  : the single clock.
- `reset`  in  1  : synchronous, active-high reset.
- `stall_i`  in  1  : decode cannot accept; IF/ID holds.
- `flush_i`  in  1  : invalidate IF/ID this cycle.
- `redirect_i`  in  1  : next fetch goes to `redirect_pc_i`.
- `redirect_pc_i`  in  32 : redirect target; bits [1:0] are forced to 0.
- `imem_req_o`  out  1  : fetch request.
- `imem_addr_o`  out  32 : word-aligned fetch address.
- `imem_ack_i`  in  1  : `imem_rdata_i` is valid for the current request.
- `imem_rdata_i`  in  32 : instruction word.
- `if_id_instr_o`  out  32 : IF/ID instruction (opcode = [31:26]).
- `if_id_pc4_o`  out  32 : PC+4 of that instruction.
- `if_id_valid_o`  out  1  : IF/ID holds a real instruction.

## Operation
- **Memory handshake**
  - `imem_req_o` and `imem_addr_o` stay stable from request assertion until the cycle with `imem_ack_i`=1.
  - `imem_ack_i` may rise in the same cycle (zero-wait) or any later cycle.
  - `imem_ack_i` is ignored when `imem_req_o`=0.
- **Registers:** fetch PC `pc_r`, request address `req_addr_r`, skid buffer (`buf_instr`, `buf_pc4`), 2-bit state.
- **FETCH**
  - `req`=1, `addr`=`req_addr_r`.
  - Ack with `redirect_i`: response discarded; `req_addr_r`←target; stay FETCH.
  - Ack with `stall_i`=1 and `if_id_valid_o`=1: response goes to the skid buffer; go to HOLD; `req_addr_r`←`req_addr_r`+4.
  - Other ack: IF/ID←(`rdata`, `addr`+4, valid=1); `req_addr_r`←`addr`+4.
  - No ack with `redirect_i`: save target in `pc_r`; go to DRAIN.
- **DRAIN**
  - `req`=1 at the old address; the response is discarded.
  - A further redirect overwrites `pc_r`.
  - On ack: `req_addr_r`←`pc_r`; go to FETCH.
- **HOLD**
  - `req`=0.
  - `stall_i`=0: IF/ID←buffer; go to FETCH.
  - `redirect_i`: buffer dropped; `req_addr_r`←target; go to FETCH. This takes priority over the unstall.
- **IF/ID update priority:** `reset` > `flush_i` > `stall_i` > load.
  - Flush sets `instr`=`NOP_INSTR`, `pc4`=0, `valid`=0.
  - Flush while in HOLD also drops the skid buffer; go to FETCH at `req_addr_r`.
- **Arithmetic:** PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- **Illegal state encodings** recover to FETCH.

## Timing
- **Reset values**
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `if_id_instr_o`=`NOP_INSTR`, `if_id_pc4_o`=0, `if_id_valid_o`=0.
  - State=FETCH, `req_addr_r`=`RESET_PC`.
- **First request:** `imem_req_o`=1 in the first cycle after `reset` deasserts.
- **Latency:** ack in cycle n → IF/ID valid in cycle n+1.
- **Throughput:** with zero-wait memory, one instruction per cycle.
- **Redirect:** redirect in cycle n with no outstanding request → request to the target in cycle n+1.
- **Reset mid-request:** the outstanding request is abandoned and `req` drops in the next cycle. Memory must tolerate this.
- **Simultaneous events:** `flush_i` and a response in the same cycle → flush wins and the response is discarded. The fetch address still advances unless `redirect_i` is also asserted.

## Structure
- **Package `mips_pkg`:** `RESET_PC` and `NOP_INSTR` defaults, plus the state enum (FETCH, DRAIN, HOLD).
- **Sub-module `if_id_register`:** implements the stall/flush/load priority. The FSM and PC logic stay in `fetch_stage`.

## Test plan
- **Reset, zero-wait memory returning `addr`^32'hA5A5_0000:**
  - `imem_addr_o` = 0x00400000, 0x00400004, … on consecutive cycles.
  - `if_id_pc4_o` = 0x00400004, … one cycle behind.
- **3-cycle ack latency, redirect to 0x00400100 one cycle after the request:**
  - Old response discarded.
  - Next request is to 0x00400100.
  - `if_id_valid_o` never shows the stale word.
- **`stall_i` held for 4 cycles while an ack arrives:**
  - IF/ID unchanged during the stall.
  - Buffered word appears the cycle after `stall_i` falls.
  - No instruction lost or duplicated.
- **`flush_i` together with `stall_i` and an ack:**
  - `if_id_valid_o`=0 and `if_id_instr_o`=0 next cycle.
  - Fetch continues at `addr`+4.
- **Redirect to 0xFFFFFFFE:**
  - Request goes to 0xFFFFFFFC.
  - Next request goes to 0x00000000 with `if_id_pc4_o`=0.
- **`reset` during DRAIN:**
  - `imem_req_o`=0 next cycle.
  - All outputs at their reset values.
  - Fetch restarts at `RESET_PC`.
